// File: rtl/l2_arbiter_if.sv
// Bundle between l2_arbiter, the two L1 miss paths and the shared L2 port.
// master: arbiter view. slave: L1/L2 environment view.
interface l2_arbiter_if #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
);
   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_rdata;
   logic              i_ready;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;
   logic              l2_read;
   logic              l2_write;
   logic [ADDR_W-1:0] l2_addr;
   logic [DATA_W-1:0] l2_wdata;
   logic [DATA_W-1:0] l2_rdata;
   logic              l2_ready;
   logic [1:0]        arb_owner;

   modport master (
      input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_ready,
      output i_rdata, i_ready, d_rdata, d_ready,
             l2_read, l2_write, l2_addr, l2_wdata, arb_owner
   );

   modport slave (
      output i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_ready,
      input  i_rdata, i_ready, d_rdata, d_ready,
             l2_read, l2_write, l2_addr, l2_wdata, arb_owner
   );
endinterface

// File: rtl/l2_arbiter.sv
// Shares one L2 port between the L1 I-cache and D-cache miss paths, D-over-I with an I starvation guard.
// Optional macro L2ARB_WB_LOCK_EN: a completed D write-back keeps the port for the following D refill.
module l2_arbiter #(
   parameter int ADDR_W       = 28,
   parameter int DATA_W       = 128,
   parameter int STARVE_LIMIT = 4
) (
   input logic          clk,
   input logic          rst,
   l2_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } state_t;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
   localparam logic [1:0] OWN_NONE   = 2'b00;
   localparam logic [1:0] OWN_I      = 2'b01;
   localparam logic [1:0] OWN_D      = 2'b10;

   state_t            r_state;
   logic [3:0]        r_starve;
   logic              r_l2_read;
   logic              r_l2_write;
   logic [ADDR_W-1:0] r_l2_addr;
   logic [DATA_W-1:0] r_l2_wdata;
   logic [1:0]        r_owner;

   logic w_d_req;
   logic w_i_req;
   logic w_lock_win;
   logic w_d_win;
   logic w_i_win;
   logic w_i_done;
   logic w_d_done;

`ifdef L2ARB_WB_LOCK_EN
   logic r_lock;
   assign w_lock_win = r_lock & bus.d_read;
`else
   assign w_lock_win = 1'b0;
`endif

   assign w_d_req = bus.d_read | bus.d_write;
   assign w_i_req = bus.i_read;
   assign w_d_win = w_d_req & (w_lock_win | ~w_i_req | (r_starve != STARVE_MAX));
   assign w_i_win = w_i_req & ~w_d_win;

   // Completion is forwarded combinationally, and only to the current owner.
   assign w_i_done    = (r_state == GRANT_I) & bus.l2_ready;
   assign w_d_done    = (r_state == GRANT_D) & bus.l2_ready;
   assign bus.i_ready = w_i_done;
   assign bus.d_ready = w_d_done;
   assign bus.i_rdata = w_i_done ? bus.l2_rdata : '0;
   assign bus.d_rdata = w_d_done ? bus.l2_rdata : '0;

   assign bus.l2_read   = r_l2_read;
   assign bus.l2_write  = r_l2_write;
   assign bus.l2_addr   = r_l2_addr;
   assign bus.l2_wdata  = r_l2_wdata;
   assign bus.arb_owner = r_owner;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_starve   <= '0;
         r_l2_read  <= 1'b0;
         r_l2_write <= 1'b0;
         r_l2_addr  <= '0;
         r_l2_wdata <= '0;
         r_owner    <= OWN_NONE;
`ifdef L2ARB_WB_LOCK_EN
         r_lock     <= 1'b0;
`endif
      end else begin
         // NOTE: all state and command registers use <= so every branch sees pre-edge values.
         case (r_state)
            IDLE: begin
               if (w_d_win) begin
                  r_state    <= GRANT_D;
                  r_owner    <= OWN_D;
                  r_l2_write <= bus.d_write;
                  r_l2_read  <= ~bus.d_write;
                  r_l2_addr  <= bus.d_addr;
                  r_l2_wdata <= bus.d_write ? bus.d_wdata : '0;
               end else if (w_i_win) begin
                  r_state    <= GRANT_I;
                  r_owner    <= OWN_I;
                  r_l2_write <= 1'b0;
                  r_l2_read  <= 1'b1;
                  r_l2_addr  <= bus.i_addr;
                  r_l2_wdata <= '0;
               end

               if (!bus.i_read || w_i_win) begin
                  r_starve <= '0;
               end else if (w_d_win && (r_starve != STARVE_MAX)) begin
                  r_starve <= r_starve + 4'd1;
               end

`ifdef L2ARB_WB_LOCK_EN
               if (w_d_win || !bus.d_read) begin
                  r_lock <= 1'b0;
               end
`endif
            end

            GRANT_I, GRANT_D: begin
               // Command stays frozen until L2 completes; requester inputs are not looked at here.
               if (bus.l2_ready) begin
                  r_state    <= IDLE;
                  r_owner    <= OWN_NONE;
                  r_l2_read  <= 1'b0;
                  r_l2_write <= 1'b0;
                  r_l2_addr  <= '0;
                  r_l2_wdata <= '0;
`ifdef L2ARB_WB_LOCK_EN
                  if ((r_state == GRANT_D) && r_l2_write) begin
                     r_lock <= 1'b1;
                  end
`endif
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboard bench for l2_arbiter: directed L1 requesters and an L2 model feed expected queues, a monitor compares.
module tb_l2_arbiter;
   localparam int ADDR_W       = 28;
   localparam int DATA_W       = 128;
   localparam int STARVE_LIMIT = 4;
   localparam logic [1:0] OWN_I = 2'b01;
   localparam logic [1:0] OWN_D = 2'b10;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   l2_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   l2_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [1:0]        owner;
      logic              rd;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      int                gap;
   } cmd_t;

   typedef struct {
      logic              is_d;
      logic [DATA_W-1:0] rdata;
      int                cmd_len;
   } resp_t;

   typedef struct {
      int                lat;
      logic [DATA_W-1:0] rdata;
   } l2_t;

   typedef struct {
      logic              rd;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [ADDR_W-1:0] addr2;
      int                chg_at;
   } dreq_t;

   cmd_t              cmd_q[$];
   resp_t             resp_q[$];
   l2_t               l2_q[$];
   dreq_t             d_q[$];
   logic [ADDR_W-1:0] i_q[$];

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   req_cyc_i = 0;
   int   req_cyc_d = 0;
   logic d_busy = 1'b0;
   logic i_busy = 1'b0;
   logic inj_ready = 1'b0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Expected L2 command, its L2 latency/data, and (optionally) the routed response.
   task automatic exp_cmd(input logic [1:0] owner, input logic rd, input logic wr,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                          input int gap, input int lat, input logic [DATA_W-1:0] rdata,
                          input bit has_resp);
      cmd_q.push_back('{owner: owner, rd: rd, wr: wr, addr: addr, wdata: wdata, gap: gap});
      l2_q.push_back('{lat: lat, rdata: rdata});
      if (has_resp) resp_q.push_back('{is_d: (owner == OWN_D), rdata: rdata, cmd_len: lat});
   endtask

   task automatic push_d(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata,
                         input logic [ADDR_W-1:0] addr2 = '0, input int chg_at = 0);
      d_q.push_back('{rd: rd, wr: wr, addr: addr, wdata: wdata, addr2: addr2, chg_at: chg_at});
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while ((cmd_q.size() != 0 || resp_q.size() != 0 || l2_q.size() != 0 || d_q.size() != 0 ||
              i_q.size() != 0 || d_busy || i_busy || bus.l2_read || bus.l2_write) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         fail({name, "_timeout"});
         cmd_q.delete();
         resp_q.delete();
         l2_q.delete();
      end
      @(posedge clk); #1;
      check({name, "_owner_idle"}, {bus.arb_owner, bus.l2_read, bus.l2_write}, '0);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // D-cache requester: holds each request until d_ready, a read+write pair keeps its read pending.
   initial begin
      dreq_t cur;
      int    age;
      cur = '{rd: 1'b0, wr: 1'b0, addr: '0, wdata: '0, addr2: '0, chg_at: 0};
      age = 0;
      bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      forever begin
         @(negedge clk); #1;
         if (!rst) begin
            d_busy = 1'b0; d_q.delete();
            bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
         end else begin
            if (d_busy) begin
               age++;
               if (cur.chg_at != 0 && age == cur.chg_at) bus.d_addr = cur.addr2;
               if (bus.d_ready) begin
                  if (cur.rd && cur.wr) begin
                     cur.wr = 1'b0; bus.d_write = 1'b0; bus.d_wdata = '0;
                  end else begin
                     d_busy = 1'b0;
                     bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
                  end
               end
            end
            if (!d_busy && d_q.size() != 0) begin
               cur = d_q.pop_front();
               d_busy = 1'b1; age = 0; req_cyc_d = cyc;
               bus.d_read = cur.rd; bus.d_write = cur.wr; bus.d_addr = cur.addr; bus.d_wdata = cur.wdata;
            end
         end
      end
   end

   initial begin
      bus.i_read = 1'b0; bus.i_addr = '0;
      forever begin
         @(negedge clk); #1;
         if (!rst) begin
            i_busy = 1'b0; i_q.delete();
            bus.i_read = 1'b0; bus.i_addr = '0;
         end else begin
            if (i_busy && bus.i_ready) begin
               i_busy = 1'b0; bus.i_read = 1'b0; bus.i_addr = '0;
            end
            if (!i_busy && i_q.size() != 0) begin
               bus.i_addr = i_q.pop_front();
               bus.i_read = 1'b1; i_busy = 1'b1; req_cyc_i = cyc;
            end
         end
      end
   end

   // L2 model: ready arrives in the lat-th cycle the command is visible.
   initial begin
      l2_t cur;
      int  cnt;
      bit  busy;
      busy = 1'b0; cnt = 0;
      cur = '{lat: 1, rdata: '0};
      bus.l2_ready = 1'b0; bus.l2_rdata = '0;
      forever begin
         @(posedge clk); #1;
         bus.l2_ready = inj_ready;
         bus.l2_rdata = inj_ready ? 128'hDEAD : '0;
         if (!rst) begin
            busy = 1'b0;
         end else if (busy) begin
            cnt--;
            if (cnt == 0) begin
               bus.l2_ready = 1'b1; bus.l2_rdata = cur.rdata; busy = 1'b0;
            end
         end else if (bus.l2_read || bus.l2_write) begin
            if (l2_q.size() == 0) begin
               fail("l2_unplanned_cmd");
               cur = '{lat: 1, rdata: '0};
            end else begin
               cur = l2_q.pop_front();
            end
            if (cur.lat <= 1) begin
               bus.l2_ready = 1'b1; bus.l2_rdata = cur.rdata;
            end else begin
               busy = 1'b1; cnt = cur.lat - 1;
            end
         end
      end
   end

   // Monitor: checks each new command, its stability while held, and every forwarded ready.
   initial begin
      logic          prev_act;
      logic          act;
      logic [159:0]  cur_cmd;
      logic [159:0]  now_cmd;
      int            cmd_start;
      cmd_t          e;
      resp_t         r;
      prev_act = 1'b0; cur_cmd = '0; cmd_start = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_act = 1'b0;
         end else begin
            act     = bus.l2_read | bus.l2_write;
            now_cmd = {bus.arb_owner, bus.l2_read, bus.l2_write, bus.l2_addr, bus.l2_wdata};
            if (act && !prev_act) begin
               cmd_start = cyc;
               cur_cmd   = now_cmd;
               if (cmd_q.size() == 0) begin
                  fail("unexpected_cmd");
               end else begin
                  e = cmd_q.pop_front();
                  check("cmd", now_cmd, {e.owner, e.rd, e.wr, e.addr, e.wdata});
                  if (e.gap != 0)
                     check("cmd_gap", cyc - ((bus.arb_owner == OWN_D) ? req_cyc_d : req_cyc_i), e.gap);
               end
            end else if (act) begin
               check("cmd_hold", now_cmd, cur_cmd);
            end
            if (bus.i_ready || bus.d_ready) begin
               if (resp_q.size() == 0) begin
                  fail("unexpected_ready");
               end else begin
                  r = resp_q.pop_front();
                  check("resp", {bus.i_ready, bus.d_ready, bus.i_rdata, bus.d_rdata},
                        {~r.is_d, r.is_d, r.is_d ? '0 : r.rdata, r.is_d ? r.rdata : '0});
                  check("ready_cycle", cyc - cmd_start + 1, r.cmd_len);
               end
            end
            prev_act = act;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic logic [511:0] all_outs();
      return {bus.l2_read, bus.l2_write, bus.l2_addr, bus.l2_wdata, bus.i_ready, bus.d_ready,
              bus.i_rdata, bus.d_rdata, bus.arb_owner};
   endfunction

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", all_outs(), '0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Single I read, ready in the 5th command cycle.
      i_q.push_back(28'h0000010);
      exp_cmd(OWN_I, 1'b1, 1'b0, 28'h10, '0, 1, 5, 128'hA5, 1'b1);
      wait_idle("single_i", 60);

      // Simultaneous requests: D write first, I two cycles after D's ready.
      push_d(1'b0, 1'b1, 28'h20, 128'h1234);
      i_q.push_back(28'h30);
      exp_cmd(OWN_D, 1'b0, 1'b1, 28'h20, 128'h1234, 1, 3, 128'hBEEF, 1'b1);
      exp_cmd(OWN_I, 1'b1, 1'b0, 28'h30, '0, 5, 2, 128'h77, 1'b1);
      wait_idle("both_req", 60);

      // Starvation guard: four D grants, then I, then remaining D.
      i_q.push_back(28'h50);
      for (int k = 0; k < 6; k++) push_d(1'b1, 1'b0, 28'h60 + 28'(k), '0);
      for (int k = 0; k < 4; k++)
         exp_cmd(OWN_D, 1'b1, 1'b0, 28'h60 + 28'(k), '0, (k == 0) ? 1 : 2, 1, 128'h100 + 128'(k), 1'b1);
      exp_cmd(OWN_I, 1'b1, 1'b0, 28'h50, '0, 9, 1, 128'h500, 1'b1);
      exp_cmd(OWN_D, 1'b1, 1'b0, 28'h64, '0, 4, 1, 128'h104, 1'b1);
      exp_cmd(OWN_D, 1'b1, 1'b0, 28'h65, '0, 2, 1, 128'h105, 1'b1);
      wait_idle("starve", 100);

      // Address changes mid-grant must not reach the L2 port.
      push_d(1'b1, 1'b0, 28'h40, '0, 28'h80, 2);
      exp_cmd(OWN_D, 1'b1, 1'b0, 28'h40, '0, 1, 6, 128'h4444, 1'b1);
      wait_idle("addr_hold", 60);

      // Write-back then refill with I pending and starve count reaching the limit.
      i_q.push_back(28'h70);
      push_d(1'b1, 1'b0, 28'h90, '0);
      push_d(1'b1, 1'b0, 28'h91, '0);
      push_d(1'b1, 1'b0, 28'h92, '0);
      push_d(1'b0, 1'b1, 28'h100, 128'hCAFE);
      push_d(1'b1, 1'b0, 28'h200, '0);
      exp_cmd(OWN_D, 1'b1, 1'b0, 28'h90, '0, 0, 1, 128'h90, 1'b1);
      exp_cmd(OWN_D, 1'b1, 1'b0, 28'h91, '0, 0, 1, 128'h91, 1'b1);
      exp_cmd(OWN_D, 1'b1, 1'b0, 28'h92, '0, 0, 1, 128'h92, 1'b1);
      exp_cmd(OWN_D, 1'b0, 1'b1, 28'h100, 128'hCAFE, 0, 1, 128'h0, 1'b1);
`ifdef L2ARB_WB_LOCK_EN
      exp_cmd(OWN_D, 1'b1, 1'b0, 28'h200, '0, 0, 1, 128'h200, 1'b1);
      exp_cmd(OWN_I, 1'b1, 1'b0, 28'h70, '0, 0, 1, 128'h70, 1'b1);
`else
      exp_cmd(OWN_I, 1'b1, 1'b0, 28'h70, '0, 0, 1, 128'h70, 1'b1);
      exp_cmd(OWN_D, 1'b1, 1'b0, 28'h200, '0, 0, 1, 128'h200, 1'b1);
`endif
      wait_idle("wb_refill", 100);

      // d_read and d_write together: write first, the read is served afterwards.
      push_d(1'b1, 1'b1, 28'h120, 128'h55);
      exp_cmd(OWN_D, 1'b0, 1'b1, 28'h120, 128'h55, 1, 2, 128'h0, 1'b1);
      exp_cmd(OWN_D, 1'b1, 1'b0, 28'h120, '0, 4, 2, 128'hF00D, 1'b1);
      wait_idle("rd_wr_pair", 60);

      // Stray l2_ready in IDLE is not forwarded.
      inj_ready = 1'b1;
      @(posedge clk); #2;
      check("stray_ready", {bus.l2_ready, bus.i_ready, bus.d_ready, bus.i_rdata, bus.d_rdata},
            {1'b1, 258'b0});
      inj_ready = 1'b0;
      @(posedge clk); #1;

      // Reset during GRANT_D, then a clean I transaction.
      push_d(1'b1, 1'b0, 28'h300, '0);
      exp_cmd(OWN_D, 1'b1, 1'b0, 28'h300, '0, 1, 20, 128'h0, 1'b0);
      n = 0;
      while (!bus.l2_read && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) fail("grant_d_wait_timeout");
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      check("reset_mid_grant", all_outs(), '0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      cmd_q.delete();
      l2_q.delete();
      @(posedge clk); #1;
      i_q.push_back(28'h400);
      exp_cmd(OWN_I, 1'b1, 1'b0, 28'h400, '0, 1, 2, 128'h99, 1'b1);
      wait_idle("after_reset", 60);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Shares the single L2 cache port between the L1 I-cache miss path and the L1 D-cache miss/write-back path.
- Sits between both L1 caches and L2.
- Registers the winning command and holds it stable on the L2 port until l2_ready.
- Routes the response to the owner only.
- Fixed D-over-I priority with a starvation guard for the I-side.

Parameters:
- ADDR_W, 28, block address width (word address bits [29:2]).
- DATA_W, 128, block data width (4 x 32-bit words).
- STARVE_LIMIT, 4, consecutive D grants while I waits before I is forced to win; legal range 1..15.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- i_read  input  1  I-cache block read request.
- i_addr  input  ADDR_W  I-cache block address.
- i_rdata  output  DATA_W  read data to I-cache.
- i_ready  output  1  one-cycle completion strobe to I-cache.
- d_read  input  1  D-cache block read (refill) request.
- d_write  input  1  D-cache block write (write-back) request.
- d_addr  input  ADDR_W  D-cache block address.
- d_wdata  input  DATA_W  D-cache write-back data.
- d_rdata  output  DATA_W  read data to D-cache.
- d_ready  output  1  one-cycle completion strobe to D-cache.
- l2_read  output  1  read command to L2.
- l2_write  output  1  write command to L2.
- l2_addr  output  ADDR_W  registered command address.
- l2_wdata  output  DATA_W  registered write data.
- l2_rdata  input  DATA_W  L2 read data.
- l2_ready  input  1  L2 completion strobe.
- arb_owner  output  2  00 none, 01 I, 10 D.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, starve count 0, lock flag 0.
  - All outputs 0: l2_read, l2_write, l2_addr, l2_wdata, i_ready, d_ready, arb_owner.
  - i_rdata and d_rdata are 0 as well.
- FSM states: IDLE, GRANT_I, GRANT_D.
- IDLE: requests are sampled on each rising edge.
  - If D requests and I does not: D wins.
  - If I requests and D does not: I wins.
  - If both request: D wins unless starve count == STARVE_LIMIT, in which case I wins.
  - Going to GRANT_x registers the command, address and wdata. arb_owner is registered too.
  - Latency: request seen at edge k, so l2_read/l2_write are high from cycle k+1.
- D command encoding: if d_read and d_write are both high, it is a write. The read stays pending for a later grant.
- I command: always a read. l2_wdata is held at 0 during I grants.
- GRANT_x: the L2 command is held constant until l2_ready is sampled high. Requester input changes are ignored during the grant.
- Same cycle as l2_ready (combinational):
  - Owner gets x_ready = 1 and x_rdata = l2_rdata.
  - The non-owner sees ready 0 and rdata 0.
- Next edge after l2_ready: go to IDLE, clear l2_read/l2_write, arb_owner = 00.
  - Earliest next command is 2 cycles after l2_ready. This one-cycle gap lets the requester drop a serviced request.
- l2_ready while in IDLE is ignored: no ready is forwarded.
- Starve count (4-bit):
  - Increments on each D grant made while i_read is high.
  - Clears on an I grant, and on any arbitration where i_read is low.
  - Saturates at STARVE_LIMIT.
- Reset mid-transaction abandons the grant; no ready is produced.
- No request is lost or duplicated: every request held until its ready receives exactly one x_ready.

Optional Feature:
- Macro: L2ARB_WB_LOCK_EN.
- Defined:
  - Completing a D write sets the lock flag.
  - In the next IDLE, if d_read is high, D is granted regardless of starve count. Write-back then refill becomes atomic.
  - The flag clears on that grant, or if d_read is low in that IDLE.
  - A locked grant still increments starve count if i_read is high.
- Undefined: no lock flag; plain priority/starvation rules apply.

Test Plan:
- Single I read, addr 28'h0000010, L2 ready after 5 cycles with rdata 128'hA5 → l2_read high from cycle 1 to 5; i_ready high only in cycle 5; i_rdata = 128'hA5; d_ready stays 0; arb_owner 01 then 00.
- I and D both request at the same edge, D write addr 28'h20 wdata 128'h1234 → D granted first (l2_write, l2_addr 28'h20, l2_wdata 128'h1234); I granted 2 cycles after D's l2_ready.
- D requests continuously back-to-back while I holds i_read, STARVE_LIMIT=4 → exactly 4 D grants, then I granted, count cleared.
- Requester changes d_addr from 28'h40 to 28'h80 mid-grant → l2_addr stays 28'h40 until l2_ready.
- Write-back 28'h100 followed by refill 28'h200, I pending, starve count = STARVE_LIMIT:
  - With L2ARB_WB_LOCK_EN: refill 28'h200 granted before I.
  - Without: I granted first.
- rst pulled low during GRANT_D → all outputs 0 immediately; after release, a new I request completes normally and no stale d_ready appears.
